// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the EX stage of the multi-cycle datapath.
//   Single-cycle ops (logic, add/sub, slt, shifts) return their result on the
//   cycle after acceptance. MUL/MULH/DIV/REM iterate one bit per cycle for
//   WIDTH cycles, using shared shift registers.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in1, in2, ALUCtl, Sign)
//   out_valid/out_ready result handshake (out)
//   busy                high while an iterative op is in progress
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [4:0]       ALUCtl,
  input  logic             Sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_NOR  = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b11000;
  localparam logic [4:0] OP_SRA  = 5'b11001;
  localparam logic [4:0] OP_MUL  = 5'b11010;
  localparam logic [4:0] OP_MULH = 5'b11011;
  localparam logic [4:0] OP_DIV  = 5'b11100;
  localparam logic [4:0] OP_REM  = 5'b11101;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  // hi: product accumulator / partial remainder; lo: multiplier / quotient
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   b_q, b_d;      // multiplicand / divisor magnitude
  logic [4:0]         op_q, op_d;
  logic               neg_q, neg_d;  // negate final result
  logic               div0_q, div0_d;

  logic               accept_s;
  logic               is_iter_s;
  logic               sgn_en_s;
  logic               s1_s, s2_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   mul_hi_s, mul_lo_s;
  logic [WIDTH:0]     shifted_s, diff_s;
  logic               ge_s;
  logic [WIDTH-1:0]   div_hi_s, div_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   iter_res_s;

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC);
  assign out       = out_q;
  // DONE can hand off its result and take a new request in the same edge
  assign in_ready  = !reset && ((state_q == S_IDLE) ||
                                ((state_q == S_DONE) && out_ready));
  assign accept_s  = in_valid && in_ready;
  assign shamt_s   = in1[SHAMT_W-1:0];

  // Single-cycle result and request classification
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    is_iter_s = 1'b0;
    case (ALUCtl)
      OP_AND:  alu_res_s = in1 & in2;
      OP_OR:   alu_res_s = in1 | in2;
      OP_ADD:  alu_res_s = in1 + in2;
      OP_SUB:  alu_res_s = in1 - in2;
      OP_SLT: begin
        if (Sign) begin
          alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
        end else begin
          alu_res_s = {{(WIDTH-1){1'b0}}, (in1 < in2)};
        end
      end
      OP_NOR:  alu_res_s = ~(in1 | in2);
      OP_XOR:  alu_res_s = in1 ^ in2;
      OP_SLL:  alu_res_s = in2 << shamt_s;
      OP_SRL:  alu_res_s = in2 >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(in2) >>> shamt_s);
      OP_MUL, OP_MULH, OP_DIV, OP_REM: is_iter_s = 1'b1;
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Operand sign handling for the iterative ops (MUL is sign-agnostic)
  always_comb begin
    sgn_en_s = Sign && (ALUCtl != OP_MUL);
    s1_s     = sgn_en_s && in1[WIDTH-1];
    s2_s     = sgn_en_s && in2[WIDTH-1];
    if (ALUCtl == OP_REM) begin
      neg_d = s1_s;
    end else begin
      neg_d = s1_s ^ s2_s;
    end
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    if (lo_q[0]) begin
      sum_s = {1'b0, hi_q} + {1'b0, b_q};
    end else begin
      sum_s = {1'b0, hi_q};
    end
    mul_hi_s  = sum_s[WIDTH:1];
    mul_lo_s  = {sum_s[0], lo_q[WIDTH-1:1]};
    shifted_s = {hi_q, lo_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, b_q};
    ge_s      = !diff_s[WIDTH];
    if (ge_s) begin
      div_hi_s = diff_s[WIDTH-1:0];
    end else begin
      div_hi_s = shifted_s[WIDTH-1:0];
    end
    div_lo_s  = {lo_q[WIDTH-2:0], ge_s};
  end

  // Sign-corrected final result of the last iteration. Divide by zero
  // needs only the quotient override: the natural remainder is the dividend
  // magnitude, which the dividend-sign correction turns back into in1.
  // Most-negative / -1 falls out naturally (quotient 2^(W-1), remainder 0).
  always_comb begin
    if (neg_q) begin
      prod_s = -{mul_hi_s, mul_lo_s};
    end else begin
      prod_s = {mul_hi_s, mul_lo_s};
    end
    case (op_q)
      OP_MUL:  iter_res_s = prod_s[WIDTH-1:0];
      OP_MULH: iter_res_s = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV: begin
        if (div0_q) begin
          iter_res_s = {WIDTH{1'b1}};
        end else if (neg_q) begin
          iter_res_s = -div_lo_s;
        end else begin
          iter_res_s = div_lo_s;
        end
      end
      OP_REM: begin
        if (neg_q) begin
          iter_res_s = -div_hi_s;
        end else begin
          iter_res_s = div_hi_s;
        end
      end
      default: iter_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    op_d    = op_q;
    div0_d  = div0_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          if (is_iter_s) begin
            state_d = S_CALC;
            cnt_d   = {CNT_W{1'b0}};
            hi_d    = {WIDTH{1'b0}};
            lo_d    = s1_s ? -in1 : in1;
            b_d     = s2_s ? -in2 : in2;
            op_d    = ALUCtl;
            div0_d  = (in2 == {WIDTH{1'b0}});
          end else begin
            state_d = S_DONE;
            out_d   = alu_res_s;
          end
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_DIV || op_q == OP_REM) begin
          hi_d = div_hi_s;
          lo_d = div_lo_s;
        end else begin
          hi_d = mul_hi_s;
          lo_d = mul_lo_s;
        end
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          out_d   = iter_res_s;
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // neg_q loads only on accept; it is held otherwise
  logic neg_load_s;
  assign neg_load_s = accept_s && is_iter_s;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      out_q   <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      op_q    <= 5'b00000;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      op_q    <= op_d;
      div0_q  <= div0_d;
      if (neg_load_s) begin
        neg_q <= neg_d;
      end else begin
        neg_q <= neg_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1, in2;
  logic [4:0]  ALUCtl;
  logic        Sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .ALUCtl(ALUCtl), .Sign(Sign),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issue one request from IDLE/DONE (out_ready=1), scramble inputs after
  // acceptance, and wait (bounded) for the result.
  task automatic do_op(input logic [4:0] ctl, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int edges,
                       output int busy_cnt, output int rdy_in_calc);
    out_ready = 1'b1;
    ALUCtl = ctl; Sign = s; in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = ~a; in2 = ~b; ALUCtl = 5'b00010; Sign = ~s;
    edges = 0; busy_cnt = 0; rdy_in_calc = 0;
    while (!out_valid && edges < 100) begin
      if (busy) busy_cnt++;
      if (busy && in_ready) rdy_in_calc++;
      @(posedge clk); #1;
      edges++;
    end
    res = out;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in1 = 32'd0; in2 = 32'd0; ALUCtl = 5'd0; Sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if (out !== 32'd0) begin bad++; $display("FAIL reset_out got %h want 0", out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    logic [4:0]  c [13] = '{5'b00010, 5'b11001, 5'b00111, 5'b00111, 5'b00110, 5'b00000,
                           5'b00001, 5'b01100, 5'b01101, 5'b10000, 5'b11000, 5'b00011, 5'b11001};
    logic        s [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] a [13] = '{32'h7FFFFFFF, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hF0F0F0F0,
                           32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd4, 32'd31, 32'h12345678, 32'd36};
    logic [31:0] b [13] = '{32'd1, 32'h80000000, 32'd1, 32'd1, 32'd1, 32'h0FF00FF0,
                           32'h0FF00FF0, 32'h0FF00FF0, 32'h0F0F0F0F, 32'd1, 32'h80000000, 32'h1, 32'h40000000};
    logic [31:0] e [13] = '{32'h80000000, 32'hF8000000, 32'd1, 32'd0, 32'hFFFFFFFF, 32'h00F000F0,
                           32'hFFF0FFF0, 32'h000F000F, 32'hF00FF00F, 32'd16, 32'd1, 32'd0, 32'h04000000};
    logic [31:0] r;
    int ed, bc, rc;
    for (int i = 0; i < 13; i++) begin
      do_op(c[i], s[i], a[i], b[i], r, ed, bc, rc);
      total++; if (r !== e[i]) begin bad++; $display("FAIL single_%0d got %h want %h", i, r, e[i]); end
      total++; if (ed !== 0) begin bad++; $display("FAIL single_lat_%0d got %0d want 0", i, ed); end
    end
  endtask

  task automatic test_iter();
    logic [4:0]  c [11] = '{5'b11010, 5'b11011, 5'b11011, 5'b11100, 5'b11101, 5'b11100,
                           5'b11101, 5'b11100, 5'b11101, 5'b11100, 5'b11101};
    logic        s [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] a [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                           32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd100, 32'd100};
    logic [31:0] b [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                           32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7};
    logic [31:0] e [11] = '{32'd1, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF,
                           32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd14, 32'd2};
    logic [31:0] r;
    int ed, bc, rc;
    for (int i = 0; i < 11; i++) begin
      do_op(c[i], s[i], a[i], b[i], r, ed, bc, rc);
      total++; if (r !== e[i]) begin bad++; $display("FAIL iter_%0d got %h want %h", i, r, e[i]); end
      total++; if (ed !== 32) begin bad++; $display("FAIL iter_lat_%0d got %0d want 32", i, ed); end
      total++; if (bc !== 32) begin bad++; $display("FAIL iter_busy_%0d got %0d want 32", i, bc); end
      total++; if (rc !== 0) begin bad++; $display("FAIL iter_ready_%0d got %0d want 0", i, rc); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ALUCtl = 5'b00010; Sign = 1'b0; in1 = 32'd1; in2 = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in1 = 32'd10; in2 = 32'd20;
    for (int i = 0; i < 5; i++) begin
      total++; if (out !== 32'd3 || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold_%0d got %h/%b want 00000003/1", i, out, out_valid);
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_%0d got %b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out !== 32'd30 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_next got %h/%b want 0000001e/1", out, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3] = '{32'd100, 32'd5, 32'hFFFFFFFF};
    logic [31:0] b [3] = '{32'd1, 32'd6, 32'd2};
    logic [31:0] e [3] = '{32'd101, 32'd11, 32'd1};
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    ALUCtl = 5'b00010; Sign = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in1 = a[i]; in2 = b[i];
      @(posedge clk); #1;
      total++; if (out !== e[i] || out_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d got %h/%b want %h/1", i, out, out_valid, e[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int ed, bc, rc;
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    ALUCtl = 5'b11010; Sign = 1'b0; in1 = 32'd3; in2 = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_abort got valid=%b busy=%b want 0/0", out_valid, busy);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) begin
        total++; bad++; $display("FAIL mid_stale got out_valid=1 want 0");
        break;
      end
    end
    do_op(5'b11010, 1'b0, 32'd6, 32'd7, r, ed, bc, rc);
    total++; if (r !== 32'd42) begin bad++; $display("FAIL mid_after got %h want 0000002a", r); end
    total++; if (ed !== 32) begin bad++; $display("FAIL mid_after_lat got %0d want 32", ed); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_iter();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the datapath ALU. It keeps the existing single-cycle operation set and encodings, and adds iterative multiply-high, divide and remainder behind a valid/ready handshake. It sits in the EX stage of the multi-cycle processor datapath. Its busy/ready status lets the control unit stall while a long operation completes.

## Interface
Parameters:
- WIDTH, 32, operand and result width; any value ≥ 8.
- SHAMT_W, $clog2(WIDTH), shift-amount width taken from in1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; a transfer occurs on an edge where in_valid && in_ready.
- in1  input  WIDTH  operand A; the shift amount for shift ops.
- in2  input  WIDTH  operand B; the value shifted for shift ops.
- ALUCtl  input  5  operation code.
- Sign  input  1  1 = signed interpretation for SLT/MULH/DIV/REM.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result on an edge where out_valid && out_ready.
- out  output  WIDTH  registered result.
- busy  output  1  high while in CALC.

## Operation
ALUCtl encodings:
- 00000 AND
- 00001 OR
- 00010 ADD
- 00110 SUB
- 00111 SLT
- 01100 NOR
- 01101 XOR
- 10000 SLL
- 11000 SRL
- 11001 SRA
- 11010 MUL (low WIDTH bits)
- 11011 MULH (high WIDTH bits)
- 11100 DIV (quotient)
- 11101 REM (remainder)
- Any other code: result 0, single-cycle path.

Single-cycle ops:
- Operations are computed from the accepted operands and registered into out.
- ADD/SUB wrap modulo 2^WIDTH.
- SLT gives {0…, lt}. When Sign=1 the compare is two's-complement; otherwise it is unsigned.
- Shifts use in1[SHAMT_W-1:0] and shift in2. SRA replicates in2[WIDTH-1].

Iterative ops (MUL, MULH, DIV, REM):
- Operands are latched at the accepting edge.
- When Sign=1, operand magnitudes are taken first. MUL ignores Sign.
- Multiply: radix-2 shift-add over WIDTH steps into a 2·WIDTH product. The product is negated if the operand signs differ (Sign=1).
- Divide: restoring, one quotient bit per step, WIDTH steps.
- Quotient sign is the XOR of the operand signs. Remainder sign follows the dividend.
- Divide by zero: quotient is all-ones; remainder is in1.
- Signed overflow (most-negative / −1): quotient is the most-negative value; remainder is 0.

FSM states IDLE, CALC, DONE:
- IDLE: in_ready=1. On accept, a single-cycle op goes to DONE with out loaded; an iterative op goes to CALC with cnt=0.
- CALC: performs one step per cycle and increments cnt. When cnt==WIDTH-1, the sign-corrected result is loaded into out and the state goes to DONE.
- DONE: out_valid=1 and out is held stable.
  - If out_ready=1 and in_valid=1, the new request is accepted in the same cycle: in_ready = out_ready in DONE, giving back-to-back operation. The next state follows the IDLE rules.
  - If out_ready=1 and in_valid=0, the state goes to IDLE.
  - If out_ready=0, the state holds.

## Timing
- Reset values: state IDLE, out_valid 0, out 0, busy 0, cnt 0.
- in_ready is 0 while reset is high and 1 on the first cycle after reset deasserts.
- Single-cycle op latency: out_valid is high on the first cycle after the accepting edge. Throughput is 1 op/cycle while out_ready stays high.
- Iterative op latency: out_valid is high exactly WIDTH cycles after the accepting edge (32 for WIDTH=32). busy is high for those WIDTH cycles.
- in_ready is 0 throughout CALC. in1/in2/ALUCtl/Sign changes during CALC are ignored.
- Backpressure: while out_valid && !out_ready, out, out_valid and state are frozen.
- Reset mid-CALC or in DONE aborts the operation. out_valid is 0 on the next cycle and the pending result is discarded.
- in_valid in CALC is not an error; the request waits until in_ready is high.

## Test plan
- ADD in1=0x7FFFFFFF, in2=1 -> out=0x80000000 with out_valid 1 cycle after accept. SRA in1=4, in2=0x80000000 -> 0xF8000000.
- SLT in1=0xFFFFFFFF, in2=1: Sign=1 -> out=1; Sign=0 -> out=0.
- in1=in2=0xFFFFFFFF: MUL -> 1. MULH Sign=0 -> 0xFFFFFFFE. MULH Sign=1 -> 0. Each has out_valid exactly 32 cycles after accept and busy high for 32 cycles.
- Sign=1, in1=0xFFFFFFF9 (−7), in2=2: DIV -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
- Divide corners: 5/0 -> DIV 0xFFFFFFFF, REM 5. 0x80000000/0xFFFFFFFF with Sign=1 -> DIV 0x80000000, REM 0.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles: out is stable and in_ready=0.
  - Then raise out_ready with a new ADD pending: it is accepted the same cycle and its result is valid the next cycle.
  - Assert reset at cycle 10 of a MUL: out_valid=0, and the next op after reset returns a correct result.
